// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one WIDTH-bit adder reused over
// WIDTH iterations, sequenced by a start/busy/done handshake.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;

  // The carry out of the add lands in the top bit of sum and is shifted into P,
  // so no separate carry flop is needed.
  always_comb begin
    addend    = p_q[0] ? {1'b0, m_q} : '0;
    sum       = {1'b0, p_q[2*WIDTH-1:WIDTH]} + addend;
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        p_d   = {sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = p_d;
          state_d   = DONE;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
